// File: rtl/lm70_pkg.sv
// Shared types and LM70 frame field positions for the LM70 SPI sequencer.
package lm70_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  localparam int TEMP_MSB = 15;
  localparam int INT_LSB  = 7;

  // Integer degrees from a raw frame; negative readings clamp to zero, fraction truncated.
  function automatic logic [7:0] lm70_int(input logic [15:0] raw);
    if (raw[TEMP_MSB]) begin
      return 8'd0;
    end else begin
      return raw[TEMP_MSB-1:INT_LSB];
    end
  endfunction

endpackage

// File: rtl/lm70_sck_gen.sv
// SCK divider for the LM70 sequencer: toggles sck every SCK_DIV clocks while i_run is high,
// flags the edge that raises sck and the edge that completes 2*NBITS toggles.
module lm70_sck_gen #(
  parameter int SCK_DIV = 2,
  parameter int NBITS   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_sck,
  output logic o_rise,
  output logic o_done
);

  localparam int DIV_W = $clog2(SCK_DIV + 1);
  localparam int TOG_W = $clog2(2 * NBITS + 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [TOG_W-1:0] r_tog_cnt;
  logic             r_sck;
  logic             w_toggle;

  assign w_toggle = i_run & (r_div_cnt == DIV_W'(SCK_DIV - 1));
  assign o_rise   = w_toggle & ~r_sck;
  assign o_done   = w_toggle & (r_tog_cnt == TOG_W'(2 * NBITS - 1));
  assign o_sck    = r_sck;

  // Divider and toggle counter; everything returns to idle-low as soon as i_run drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_tog_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (!i_run) begin
      r_div_cnt <= '0;
      r_tog_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_toggle) begin
      r_div_cnt <= '0;
      r_tog_cnt <= r_tog_cnt + TOG_W'(1);
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lm70_spi_sequencer.sv
// LM70 SPI read sequencer: one-shot or periodic reads, single-deep request queue.
// Optional LM70_AVG_EN: temp_int becomes the mean of the last four integer samples.
module lm70_spi_sequencer
  import lm70_pkg::*;
#(
  parameter int SCK_DIV  = 2,
  parameter int NBITS    = 16,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int PERIOD   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        auto_en,
  input  logic        req,
  input  logic        sio,
  output logic        cs_n,
  output logic        sck,
  output logic        busy,
  output logic        temp_valid,
  output logic [15:0] temp_raw,
  output logic [7:0]  temp_int
);

  localparam int PER_W = $clog2(PERIOD + 1);
  localparam int CNT_W = $clog2(((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PER_W-1:0] r_per_cnt;
  logic             r_pending;
  logic             r_cs_n;
  logic             r_busy;
  logic             r_temp_valid;
  logic [15:0]      r_shift;
  logic [15:0]      r_temp_raw;
  logic [7:0]       r_temp_int;

  logic             w_sck, w_rise, w_done, w_tick, w_trigger, w_start;
  logic [7:0]       w_new_int, w_int_nxt;

  assign w_tick    = auto_en & (r_per_cnt == PER_W'(PERIOD - 1));
  assign w_trigger = req | w_tick;
  assign w_start   = ena & (w_trigger | r_pending);
  assign w_new_int = lm70_int(r_shift);

  lm70_sck_gen #(
    .SCK_DIV (SCK_DIV),
    .NBITS   (NBITS)
  ) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (r_state == ST_SHIFT),
    .o_sck  (w_sck),
    .o_rise (w_rise),
    .o_done (w_done)
  );

  // Auto-sample period counter, parked at zero while auto sampling is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
    end else if (!auto_en) begin
      r_per_cnt <= '0;
    end else if (r_per_cnt == PER_W'(PERIOD - 1)) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + PER_W'(1);
    end
  end

`ifdef LM70_AVG_EN
  logic [7:0] r_h1, r_h2, r_h3;
  logic       r_hist_vld;
  logic [9:0] w_sum;

  // Until the first frame lands, the new sample stands in for the whole history.
  always_comb begin
    if (r_hist_vld) begin
      w_sum = {2'b00, w_new_int} + {2'b00, r_h1} + {2'b00, r_h2} + {2'b00, r_h3};
    end else begin
      w_sum = {w_new_int, 2'b00};
    end
  end

  assign w_int_nxt = w_sum[9:2];

  // History of the three previous integer samples, advanced on each latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1       <= 8'd0;
      r_h2       <= 8'd0;
      r_h3       <= 8'd0;
      r_hist_vld <= 1'b0;
    end else if (r_state == ST_LATCH) begin
      r_h1       <= w_new_int;
      r_h2       <= r_hist_vld ? r_h1 : w_new_int;
      r_h3       <= r_hist_vld ? r_h2 : w_new_int;
      r_hist_vld <= 1'b1;
    end else begin
      r_hist_vld <= r_hist_vld;
    end
  end
`else
  assign w_int_nxt = w_new_int;
`endif

  // Transaction FSM with registered chip select, busy, and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_cs_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_temp_valid <= 1'b0;
      r_shift      <= 16'h0000;
      r_temp_raw   <= 16'h0000;
      r_temp_int   <= 8'd0;
    end else begin
      r_temp_valid <= 1'b0;
      if (w_trigger && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_cs_n <= 1'b1;
          if (w_start) begin
            r_state   <= ST_SETUP;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_shift <= {r_shift[14:0], sio};
          end
          if (w_done) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
            r_state <= ST_LATCH;
            r_cs_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          r_temp_raw   <= r_shift;
          r_temp_int   <= w_int_nxt;
          r_temp_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cs_n       = r_cs_n;
  assign sck        = w_sck;
  assign busy       = r_busy;
  assign temp_valid = r_temp_valid;
  assign temp_raw   = r_temp_raw;
  assign temp_int   = r_temp_int;

endmodule

// File: tb/tb_lm70_spi_sequencer.sv
// Directed self-checking bench for lm70_spi_sequencer with an LM70 serial-data model.
// Expected temp_int values follow LM70_AVG_EN when the bench is built with it.
module tb_lm70_spi_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        auto_en;
  logic        req;
  logic        sio;
  logic        cs_n;
  logic        sck;
  logic        busy;
  logic        temp_valid;
  logic [15:0] temp_raw;
  logic [7:0]  temp_int;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          rise_cnt = 0;
  int          bit_idx  = -1;
  logic [15:0] frame    = 16'h0000;

  lm70_spi_sequencer #(
    .SCK_DIV  (2),
    .NBITS    (16),
    .CS_SETUP (2),
    .CS_HOLD  (2),
    .PERIOD   (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .auto_en    (auto_en),
    .req        (req),
    .sio        (sio),
    .cs_n       (cs_n),
    .sck        (sck),
    .busy       (busy),
    .temp_valid (temp_valid),
    .temp_raw   (temp_raw),
    .temp_int   (temp_int)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    forever begin
      @(posedge sck);
      rise_cnt = rise_cnt + 1;
    end
  end

  // LM70 model: MSB presented when cs_n falls, next bit after each sck fall.
  initial begin
    logic pc;
    logic ps;
    pc = 1'b1;
    ps = 1'b0;
    forever begin
      @(cs_n or sck);
      if (pc === 1'b1 && cs_n === 1'b0) begin
        bit_idx = 15;
      end else if (ps === 1'b1 && sck === 1'b0) begin
        bit_idx = bit_idx - 1;
      end
      pc = cs_n;
      ps = sck;
    end
  end

  assign sio = (bit_idx >= 0 && bit_idx <= 15) ? frame[bit_idx[3:0]] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Issues one request and returns edges from the sampling edge (counted as 1) to temp_valid.
  task automatic run_frame(input logic [15:0] f, input int budget, output int lat, output int cs_low);
    frame    = f;
    rise_cnt = 0;
    lat      = -1;
    cs_low   = 0;
    pulse_req();
    for (int e = 1; e <= budget; e++) begin
      if (cs_n === 1'b0) cs_low = cs_low + 1;
      if (temp_valid === 1'b1) begin
        lat = e;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (temp_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_cs_fall(input int budget, output int at);
    logic prev;
    prev = cs_n;
    at   = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && cs_n === 1'b0) begin
        at = cyc;
        break;
      end
      prev = cs_n;
    end
  endtask

  task automatic quiet_window(input int len, output int cs_low, output int vld);
    cs_low = 0;
    vld    = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1) cs_low = cs_low + 1;
      if (temp_valid !== 1'b0) vld = vld + 1;
    end
  endtask

  initial begin
    int          lat;
    int          cs_low;
    int          n;
    int          vld;
    int          c0;
    int          t1;
    int          t2;
    logic [15:0] frames[4];
    logic [7:0]  exp6[4];
    logic [7:0]  exp_t1;
    logic [7:0]  exp_t2;
    logic [7:0]  exp_t3;

`ifdef LM70_AVG_EN
    exp_t1 = 8'd25;
    exp_t2 = 8'd18;
    exp_t3 = 8'd25;
    exp6   = '{8'd20, 8'd21, 8'd23, 8'd26};
`else
    exp_t1 = 8'd25;
    exp_t2 = 8'd0;
    exp_t3 = 8'd50;
    exp6   = '{8'd20, 8'd24, 8'd28, 8'd32};
`endif
    frames = '{16'h0A00, 16'h0C00, 16'h0E00, 16'h1000};

    rst_n   = 1'b0;
    ena     = 1'b0;
    auto_en = 1'b0;
    req     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", temp_valid, 0);
    check("rst_raw", temp_raw, 0);
    check("rst_int", temp_int, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single read of +25 C
    run_frame(16'h0C80, 200, lat, cs_low);
    check("t1_latency", lat, 70);
    check("t1_cs_low", cs_low, 68);
    check("t1_rises", rise_cnt, 16);
    check("t1_raw", temp_raw, 16'h0C80);
    check("t1_int", temp_int, exp_t1);
    check("t1_busy_after", busy, 0);
    @(negedge clk);
    check("t1_valid_pulse", temp_valid, 0);

    // 2: negative reading clamps
    run_frame(16'hFB00, 200, lat, cs_low);
    check("t2_latency", lat, 70);
    check("t2_raw", temp_raw, 16'hFB00);
    check("t2_int", temp_int, exp_t2);

    // 3: queued request runs back-to-back; a further request in the same frame is dropped
    frame = 16'h0C80;
    pulse_req();
    repeat (20) @(negedge clk);
    check("t3_busy_shift", busy, 1);
    pulse_req();
    repeat (10) @(negedge clk);
    pulse_req();
    wait_valid(100, n);
    check("t3_a_found", (n > 0), 1);
    check("t3_a_raw", temp_raw, 16'h0C80);
    frame = 16'h1900;
    check("t3_gap_cs_n", cs_n, 1);
    @(negedge clk);
    check("t3_b_start", cs_n, 0);
    wait_valid(100, n);
    check("t3_b_found", (n > 0), 1);
    check("t3_b_raw", temp_raw, 16'h1900);
    check("t3_b_int", temp_int, exp_t3);
    quiet_window(200, cs_low, vld);
    check("t3_third_dropped", cs_low, 0);

    // 4: periodic sampling, then ena low mid-frame
    frame = 16'h0C80;
    @(negedge clk);
    auto_en = 1'b1;
    c0 = cyc;
    wait_cs_fall(150, t1);
    check("t4_first_tick", t1 - c0, 100);
    wait_cs_fall(150, t2);
    check("t4_period", t2 - t1, 100);
    repeat (20) @(negedge clk);
    ena = 1'b0;
    wait_valid(100, n);
    check("t4_frame_completes", (n > 0), 1);
    quiet_window(300, cs_low, vld);
    check("t4_no_activity", cs_low, 0);
    auto_en = 1'b0;
    ena     = 1'b1;
    repeat (5) @(negedge clk);

    // 5: asynchronous reset in the middle of SHIFT
    frame = 16'h0C80;
    pulse_req();
    for (int i = 0; i < 100; i++) begin
      if (sck === 1'b1) break;
      @(negedge clk);
    end
    check("t5_pre_sck", sck, 1);
    check("t5_pre_cs_n", cs_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_n", cs_n, 1);
    check("t5_sck", sck, 0);
    check("t5_busy", busy, 0);
    check("t5_raw", temp_raw, 0);
    check("t5_int", temp_int, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_window(100, cs_low, vld);
    check("t5_no_valid", vld, 0);
    check("t5_no_cs", cs_low, 0);

    // 6: sequence of rising readings
    for (int k = 0; k < 4; k++) begin
      run_frame(frames[k], 200, lat, cs_low);
      check($sformatf("t6_latency_%0d", k), lat, 70);
      check($sformatf("t6_raw_%0d", k), temp_raw, frames[k]);
      check($sformatf("t6_int_%0d", k), temp_int, exp6[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
